// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the trainable neuron.
// Used by neuron (top) and neuron_mac.
package neuron_pkg;

  localparam int W_DEF  = 16;
  localparam int F_DEF  = 8;
  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    ACC,
    PRD,
    DELTA,
    ERR,
    FBK,
    UPD
  } state_t;

  // Clamp a wide signed value into the two's complement range of a w-bit word.
  function automatic wide_t sat(input wide_t value, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Single shared multiplier: registered signed product, arithmetic shift by F
// (or F+K for learning-rate steps), with a saturated W-bit view of the result.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int F = F_DEF,
  parameter int K = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  input  logic                  lr_i,
  output logic signed [2*W-1:0] prod_o,
  output logic signed [W-1:0]   sat_o
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0] mul;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_q;

  always_comb begin
    mul    = PW'(a_i) * PW'(b_i);
    prod_d = lr_i ? (mul >>> (F + K)) : (mul >>> F);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prod_q <= '0;
    else         prod_q <= prod_d;
  end

  assign prod_o = prod_q;
  assign sat_o  = W'(sat(wide_t'(prod_q), W));

endmodule

// File: rtl/neuron.sv
// Trainable neuron: serial dot product + bias, backprop feedback and in-place
// weight/bias update. Define NEURON_RELU_EN for ReLU activation.
module neuron
  import neuron_pkg::*;
#(
  parameter int N = 2,
  parameter int W = W_DEF,
  parameter int F = F_DEF,
  parameter int K = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  train,
  input  logic                  operand_valid,
  input  logic [N-1:0][W-1:0]   operand_data,
  output logic                  operand_ready,
  output logic                  product_valid,
  output logic [W-1:0]          product_data,
  input  logic                  product_ready,
  input  logic                  delta_valid,
  input  logic [W-1:0]          delta_data,
  output logic                  delta_ready,
  output logic                  feedback_valid,
  output logic [N-1:0][W-1:0]   feedback_data,
  input  logic                  feedback_ready
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * W + $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, nxt;
  logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
  logic signed [W-1:0]   w_q  [N];
  logic signed [W-1:0]   w_d  [N];
  logic signed [W-1:0]   x_q  [N];
  logic signed [W-1:0]   x_d  [N];
  logic signed [W-1:0]   fb_q [N];
  logic signed [W-1:0]   fb_d [N];
  logic signed [W-1:0]   bias_q, bias_d;
  logic signed [W-1:0]   delta_q, delta_d, delta_in;
  logic signed [W-1:0]   prod_q, prod_d;
  logic                  neg_q, neg_d;

  logic signed [W-1:0]   mac_a, mac_b, mac_sat;
  logic signed [2*W-1:0] mac_prod;
  logic                  mac_lr;

  function automatic logic signed [W-1:0] narrow(input wide_t v);
    narrow = W'(sat(v, W));
  endfunction

  neuron_mac #(.W(W), .F(F), .K(K)) u_mac (
    .clk_i  (clock),
    .rst_ni (reset),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .lr_i   (mac_lr),
    .prod_o (mac_prod),
    .sat_o  (mac_sat)
  );

  // A non-positive pre-activation sum blocks learning through a ReLU.
  assign delta_in = (RELU && neg_q) ? '0 : delta_data;
  assign nxt      = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  assign acc_sum  = acc_q + AW'(mac_prod);

  // Multiplier operands are issued one cycle ahead of their consumer, so the
  // handshake cycles of DELTA and FBK prime the first ERR/UPD product.
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    acc_d          = acc_q;
    w_d            = w_q;
    x_d            = x_q;
    fb_d           = fb_q;
    bias_d         = bias_q;
    delta_d        = delta_q;
    prod_d         = prod_q;
    neg_d          = neg_q;
    operand_ready  = 1'b0;
    product_valid  = 1'b0;
    delta_ready    = 1'b0;
    feedback_valid = 1'b0;
    mac_a          = w_q[cnt_q];
    mac_b          = x_q[cnt_q];
    mac_lr         = 1'b0;

    case (state_q)
      IDLE: begin
        operand_ready = 1'b1;
        acc_d         = AW'(bias_q);
        if (operand_valid) begin
          for (int i = 0; i < N; i++) x_d[i] = operand_data[i];
          state_d = MAC;
        end
      end
      MAC: begin
        cnt_d = nxt;
        if (cnt_q != '0) acc_d = acc_sum;
        if (cnt_q == LAST) state_d = ACC;
      end
      ACC: begin
        acc_d   = acc_sum;
        neg_d   = acc_sum[AW-1] | (acc_sum == '0);
        prod_d  = (RELU && neg_d) ? '0 : narrow(wide_t'(acc_sum));
        state_d = PRD;
      end
      PRD: begin
        product_valid = 1'b1;
        if (product_ready) state_d = train ? DELTA : IDLE;
      end
      DELTA: begin
        delta_ready = 1'b1;
        mac_a       = w_q[0];
        mac_b       = delta_in;
        if (delta_valid) begin
          delta_d = delta_in;
          state_d = ERR;
        end
      end
      ERR: begin
        mac_a       = w_q[nxt];
        mac_b       = delta_q;
        cnt_d       = nxt;
        fb_d[cnt_q] = mac_sat;
        if (cnt_q == LAST) state_d = FBK;
      end
      FBK: begin
        feedback_valid = 1'b1;
        mac_a          = delta_q;
        mac_b          = x_q[0];
        mac_lr         = 1'b1;
        if (feedback_ready) state_d = UPD;
      end
      UPD: begin
        mac_a      = delta_q;
        mac_b      = x_q[nxt];
        mac_lr     = 1'b1;
        cnt_d      = nxt;
        w_d[cnt_q] = narrow(wide_t'(w_q[cnt_q]) + wide_t'(mac_prod));
        if (cnt_q == LAST) begin
          bias_d  = narrow(wide_t'(bias_q) + wide_t'(delta_q >>> K));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) feedback_data[i] = fb_q[i];
  end

  assign product_data = prod_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bias_q  <= '0;
      delta_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_q[i]  <= '0;
        x_q[i]  <= '0;
        fb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      delta_q <= delta_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      w_q     <= w_d;
      x_q     <= x_d;
      fb_q    <= fb_d;
    end
  end

endmodule
